// File: rtl/pipe_cpu_pkg.sv
// pipe_cpu_pkg: opcodes, ALU ops, decoded-control type and decoder for pipe_cpu
package pipe_cpu_pkg;
  localparam int REG_W = 2;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       beq;
    logic       bne;
    logic [2:0] alu_op;
  } ctrl_t;
  function automatic ctrl_t decode(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_ADD; end
      OP_SUB:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_SUB; end
      OP_AND:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_AND; end
      OP_OR:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OR;  end
      OP_SLT:  begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_SLT; end
      OP_ADDI: begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
      OP_LW:   begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      OP_SW:   begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BEQ:  c.beq = 1'b1;
      OP_BNE:  c.bne = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/pipe_regfile.sv
// pipe_regfile: NREGS x XLEN register file, 2 read / 1 write, write-through, r0 hardwired to 0
//   clock, reset : clock and synchronous active-high clear
//   ra1/ra2 -> rd1/rd2 : combinational read ports
//   we, wa, wd  : write port, committed at the rising edge
module pipe_regfile
  import pipe_cpu_pkg::*;
#(
  parameter int XLEN  = 16,
  parameter int NREGS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  input  logic             we,
  input  logic [REG_W-1:0] wa,
  input  logic [XLEN-1:0]  wd,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2
);
  logic [XLEN-1:0] r_regs [NREGS];
  always_ff @(posedge clock) begin
    if (reset)
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    else if (we && wa != '0)
      r_regs[wa] <= wd;
  end
  // a same-cycle write bypasses the array so ID sees the retiring value
  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : r_regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : r_regs[ra2];
endmodule

// File: rtl/pipe_cpu.sv
// pipe_cpu: 5-stage (IF ID EX MEM WB) 16-bit-instruction pipelined CPU
//   clock, reset           : single clock, synchronous active-high reset
//   imem_addr/imem_rdata   : instruction fetch (address = pc, combinational read)
//   dmem_addr/rdata/we/wdata : MEM-stage data access, store strobe sampled at the edge
//   pc                     : current fetch PC
//   wb_valid/wb_rd/wb_data : one pulse per retiring register write
//   stall                  : IF/ID held this cycle
//   `define PIPE_CPU_FORWARDING_EN enables EX/MEM and MEM/WB operand forwarding
module pipe_cpu
  import pipe_cpu_pkg::*;
#(
  parameter int XLEN  = 16,
  parameter int NREGS = 4
) (
  input  logic             clock,
  input  logic             reset,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [15:0]      imem_rdata,
  output logic [XLEN-1:0]  dmem_addr,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [XLEN-1:0]  pc,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             stall
);
  logic [XLEN-1:0]  r_pc;
  logic             r_fd_valid;
  logic [15:0]      r_fd_ir;
  logic [XLEN-1:0]  r_fd_pc;
  logic             r_dx_valid;
  ctrl_t            r_dx_c;
  logic [XLEN-1:0]  r_dx_pc, r_dx_a, r_dx_b, r_dx_imm;
  logic [REG_W-1:0] r_dx_rt, r_dx_rd;
`ifdef PIPE_CPU_FORWARDING_EN
  logic [REG_W-1:0] r_dx_rs;
`endif
  logic             r_xm_valid, r_xm_m2r, r_xm_rw, r_xm_mw;
  logic [XLEN-1:0]  r_xm_alu, r_xm_b;
  logic [REG_W-1:0] r_xm_dst;
  logic             r_mw_valid, r_mw_rw;
  logic [REG_W-1:0] r_mw_dst;
  logic [XLEN-1:0]  r_mw_data;
  ctrl_t            w_c;
  logic [REG_W-1:0] w_rs, w_rt, w_dx_dst;
  logic [XLEN-1:0]  w_imm, w_ra, w_rb, w_fa, w_fb, w_opb, w_alu, w_target;
  logic             w_use_rs, w_use_rt, w_dx_wr, w_xm_wr, w_mw_wr, w_hazard, w_taken;
  assign w_rs  = r_fd_ir[11:10];
  assign w_rt  = r_fd_ir[9:8];
  assign w_imm = {{(XLEN-8){r_fd_ir[7]}}, r_fd_ir[7:0]};
  assign w_c   = decode(r_fd_ir[15:12]);
  assign w_use_rs = w_c.reg_write | w_c.mem_write | w_c.beq | w_c.bne;
  assign w_use_rt = (w_c.reg_write & ~w_c.alu_src) | w_c.mem_write | w_c.beq | w_c.bne;
  assign w_dx_dst = r_dx_c.reg_dst ? r_dx_rd : r_dx_rt;
  // producers that really write a register (r0 writes never matter)
  assign w_dx_wr = r_dx_valid & r_dx_c.reg_write & (w_dx_dst != '0);
  assign w_xm_wr = r_xm_valid & r_xm_rw & (r_xm_dst != '0);
  assign w_mw_wr = r_mw_valid & r_mw_rw & (r_mw_dst != '0);
  pipe_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clock(clock), .reset(reset),
    .ra1(w_rs), .ra2(w_rt),
    .we(wb_valid), .wa(r_mw_dst), .wd(r_mw_data),
    .rd1(w_ra), .rd2(w_rb)
  );
`ifdef PIPE_CPU_FORWARDING_EN
  // EX/MEM is younger than MEM/WB, so it is checked first; a load's EX/MEM value is an address
  assign w_fa = (w_xm_wr & ~r_xm_m2r & r_xm_dst == r_dx_rs) ? r_xm_alu :
                (w_mw_wr & r_mw_dst == r_dx_rs) ? r_mw_data : r_dx_a;
  assign w_fb = (w_xm_wr & ~r_xm_m2r & r_xm_dst == r_dx_rt) ? r_xm_alu :
                (w_mw_wr & r_mw_dst == r_dx_rt) ? r_mw_data : r_dx_b;
  assign w_hazard = r_fd_valid & w_dx_wr & r_dx_c.mem_to_reg &
                    ((w_use_rs & w_dx_dst == w_rs) | (w_use_rt & w_dx_dst == w_rt));
`else
  // MEM/WB is covered by the register file write-through
  assign w_fa = r_dx_a;
  assign w_fb = r_dx_b;
  assign w_hazard = r_fd_valid &
                    ((w_use_rs & ((w_dx_wr & w_dx_dst == w_rs) | (w_xm_wr & r_xm_dst == w_rs))) |
                     (w_use_rt & ((w_dx_wr & w_dx_dst == w_rt) | (w_xm_wr & r_xm_dst == w_rt))));
`endif
  assign w_opb = r_dx_c.alu_src ? r_dx_imm : w_fb;
  assign w_alu = r_dx_c.alu_op == ALU_SUB ? w_fa - w_opb :
                 r_dx_c.alu_op == ALU_AND ? w_fa & w_opb :
                 r_dx_c.alu_op == ALU_OR  ? w_fa | w_opb :
                 r_dx_c.alu_op == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(w_fa) < $signed(w_opb)} :
                 w_fa + w_opb;
  assign w_taken  = r_dx_valid & ((r_dx_c.beq & w_fa == w_fb) | (r_dx_c.bne & w_fa != w_fb));
  assign w_target = r_dx_pc + XLEN'(2) + (r_dx_imm << 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc       <= '0;
      r_fd_valid <= 1'b0;
      r_dx_valid <= 1'b0;
      r_xm_valid <= 1'b0;
      r_mw_valid <= 1'b0;
    end else begin
      r_pc <= w_taken ? w_target : w_hazard ? r_pc : r_pc + XLEN'(2);
      // a taken branch overrides the hold and squashes the fetched slot
      if (!w_hazard || w_taken) begin
        r_fd_valid <= ~w_taken;
        r_fd_ir    <= imem_rdata;
        r_fd_pc    <= r_pc;
      end
      r_dx_valid <= r_fd_valid & ~w_hazard & ~w_taken;
      r_dx_c     <= w_c;
      r_dx_pc    <= r_fd_pc;
      r_dx_a     <= w_ra;
      r_dx_b     <= w_rb;
      r_dx_imm   <= w_imm;
      r_dx_rt    <= w_rt;
      r_dx_rd    <= r_fd_ir[7:6];
`ifdef PIPE_CPU_FORWARDING_EN
      r_dx_rs    <= w_rs;
`endif
      r_xm_valid <= r_dx_valid;
      r_xm_m2r   <= r_dx_c.mem_to_reg;
      r_xm_rw    <= r_dx_c.reg_write;
      r_xm_mw    <= r_dx_c.mem_write;
      r_xm_alu   <= w_alu;
      r_xm_b     <= w_fb;
      r_xm_dst   <= w_dx_dst;
      r_mw_valid <= r_xm_valid;
      r_mw_rw    <= r_xm_rw;
      r_mw_dst   <= r_xm_dst;
      r_mw_data  <= r_xm_m2r ? dmem_rdata : r_xm_alu;
    end
  end
  assign pc         = r_pc;
  assign imem_addr  = r_pc;
  assign dmem_addr  = r_xm_alu;
  assign dmem_wdata = r_xm_b;
  // reset gates the strobes so nothing in flight commits on a reset edge
  assign dmem_we    = r_xm_valid & r_xm_mw & ~reset;
  assign wb_valid   = w_mw_wr & ~reset;
  assign wb_rd      = r_mw_dst;
  assign wb_data    = r_mw_data;
  assign stall      = w_hazard & ~w_taken & ~reset;
endmodule
